// File: rtl/axi_fifo_flopn.sv
// Register-based AXI-Stream FIFO: circular buffer of DEPTH flops with count, space and occupancy.
// Optional macro AXI_FIFO_FLOPN_BYPASS_EN adds a zero-latency pass-through when empty.
module axi_fifo_flopn #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [CW-1:0]    space,
  output logic [CW-1:0]    occupied
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, bypass, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

`ifdef AXI_FIFO_FLOPN_BYPASS_EN
  // Empty with both sides ready: the beat flows straight through and is never stored.
  assign bypass  = reset_n & empty & i_tvalid & o_tready;
  assign o_tdata = bypass ? i_tdata : mem_q[rd_ptr_q];
`else
  assign bypass  = 1'b0;
  assign o_tdata = mem_q[rd_ptr_q];
`endif

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign i_tready = reset_n & (~full | o_tready);
  assign o_tvalid = ~empty | bypass;
  assign push     = i_tvalid & i_tready & ~bypass;
  assign pop      = ~empty & o_tready;
  assign occupied = count_q;
  assign space    = CW'(DEPTH) - count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push && !clear) begin
      mem_q[wr_ptr_q] <= i_tdata;
    end
  end

endmodule

// File: tb/tb_axi_fifo_flopn.sv
// Bench for axi_fifo_flopn: queue-based reference model checked every cycle, plus directed scenarios.
module tb_axi_fifo_flopn;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] i_tdata = '0;
  logic             i_tvalid = 1'b0;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tvalid;
  logic             o_tready = 1'b0;
  logic [CW-1:0]    space, occupied;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] q[$];

  axi_fifo_flopn #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .space    (space),
    .occupied (occupied)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic vi, input logic [WIDTH-1:0] d, input logic ro, input logic cl);
    i_tvalid = vi;
    i_tdata  = d;
    o_tready = ro;
    clear    = cl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered queue of stored beats.
  always @(posedge clk or negedge reset_n) begin : model
    int n;
    logic byp, do_push, do_pop;
    if (!reset_n || clear) begin
      q.delete();
    end else begin
      n   = q.size();
      byp = 1'b0;
`ifdef AXI_FIFO_FLOPN_BYPASS_EN
      byp = (n == 0) && i_tvalid && o_tready;
`endif
      do_pop  = (n != 0) && o_tready;
      do_push = i_tvalid && ((n != int'(DEPTH)) || o_tready) && !byp;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(i_tdata);
    end
  end

  always @(negedge clk) begin : compare
    int n;
    logic byp, ev;
    logic [WIDTH-1:0] ed;
    n   = q.size();
    byp = 1'b0;
`ifdef AXI_FIFO_FLOPN_BYPASS_EN
    byp = reset_n && (n == 0) && i_tvalid && o_tready;
`endif
    ev = (n != 0) || byp;
    ed = (n != 0) ? q[0] : i_tdata;
    chk("m_i_tready", 32'(i_tready), 32'(reset_n && ((n != int'(DEPTH)) || o_tready)));
    chk("m_o_tvalid", 32'(o_tvalid), 32'(ev));
    if (ev) chk("m_o_tdata", 32'(o_tdata), 32'(ed));
    chk("m_occupied", 32'(occupied), 32'(n));
    chk("m_space", 32'(space), 32'(int'(DEPTH) - n));
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst_i_tready", 32'(i_tready), 0);
    chk("rst_o_tvalid", 32'(o_tvalid), 0);
    chk("rst_occupied", 32'(occupied), 0);
    chk("rst_space", 32'(space), 4);
    tick();
    tick();
    reset_n = 1'b1;

    // Fill to full with downstream stalled.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_i_tready", 32'(i_tready), 0);
    chk("full_occupied", 32'(occupied), 4);
    chk("full_space", 32'(space), 0);
    chk("full_o_tdata", 32'(o_tdata), 32'hA0);

    // Push into full while popping.
    set_in(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("fullpp_i_tready", 32'(i_tready), 1);
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpp_occupied", 32'(occupied), 4);
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", 32'(o_tdata), 32'(8'(8'hA1 + k)));
      tick();
    end
    chk("drain_empty", 32'(o_tvalid), 0);

    // Continuous streaming.
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
`ifdef AXI_FIFO_FLOPN_BYPASS_EN
      chk("stream_data", 32'(o_tdata), 32'(8'(8'h10 + i)));
      chk("stream_occ", 32'(occupied), 0);
`else
      if (i == 0) chk("stream_first_invalid", 32'(o_tvalid), 0);
      else begin
        chk("stream_data", 32'(o_tdata), 32'(8'(8'h10 + i - 1)));
        chk("stream_occ", 32'(occupied), 1);
      end
`endif
      tick();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef AXI_FIFO_FLOPN_BYPASS_EN
    chk("stream_last", 32'(o_tdata), 32'h23);
`endif
    tick();

    // Clear with a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_clear_occ", 32'(occupied), 3);
    set_in(1'b1, 8'h55, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    chk("clear_occ", 32'(occupied), 0);
    chk("clear_o_tvalid", 32'(o_tvalid), 0);
    for (int k = 0; k < 3; k++) begin
      set_in(k == 0, 8'hC0, 1'b1, 1'b0);
      chk("no_55", 32'(o_tvalid && (o_tdata == 8'h55)), 0);
      tick();
    end

    // Asynchronous reset with two beats stored.
    set_in(1'b1, 8'hD0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'hD1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(occupied), 2);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_o_tvalid", 32'(o_tvalid), 0);
    chk("arst_space", 32'(space), 4);
    chk("arst_occupied", 32'(occupied), 0);
    chk("arst_i_tready", 32'(i_tready), 0);
    tick();
    reset_n = 1'b1;
    set_in(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(o_tvalid), 1);
    chk("post_rst_data", 32'(o_tdata), 32'h77);
    chk("post_rst_occ", 32'(occupied), 1);
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    tick();

`ifdef AXI_FIFO_FLOPN_BYPASS_EN
    set_in(1'b1, 8'h99, 1'b1, 1'b0);
    chk("byp_valid", 32'(o_tvalid), 1);
    chk("byp_data", 32'(o_tdata), 32'h99);
    chk("byp_occ", 32'(occupied), 0);
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    chk("byp_after_occ", 32'(occupied), 0);
    chk("byp_after_valid", 32'(o_tvalid), 0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 49) == 0));
      tick();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) tick();
    chk("final_empty", 32'(occupied), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_fifo_flopn.md
AXI_FIFO_FLOPN -- requirements
Module: axi_fifo_flopn

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning data bits per beat (1..512).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning number of register entries (2..16, power of two not required).
REQ-003 The module SHALL define CW = $clog2(DEPTH+1) as the width of the count outputs.
REQ-004 The module SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The module SHALL have port clear, input, 1, meaning synchronous flush, active-high.
REQ-007 The module SHALL have port i_tdata, input, WIDTH, meaning the input beat.
REQ-008 The module SHALL have port i_tvalid, input, 1, meaning the input beat is valid.
REQ-009 The module SHALL have port i_tready, output, 1, meaning the FIFO accepts the input beat.
REQ-010 The module SHALL have port o_tdata, output, WIDTH, meaning the head beat.
REQ-011 The module SHALL have port o_tvalid, output, 1, meaning the head beat is valid.
REQ-012 The module SHALL have port o_tready, input, 1, meaning the downstream accepts the head beat.
REQ-013 The module SHALL have port space, output, CW, meaning free entries (DEPTH - count).
REQ-014 The module SHALL have port occupied, output, CW, meaning stored entries (count).

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH registers, using rd_ptr and wr_ptr that wrap from DEPTH-1 to 0, plus a count register (0..DEPTH).
REQ-016 Push SHALL occur when i_tvalid & i_tready: mem[wr_ptr] <= i_tdata, and wr_ptr advances.
REQ-017 Pop SHALL occur when o_tvalid & o_tready: rd_ptr advances.
REQ-018 On each clock, count SHALL increment on push only, decrement on pop only, and remain unchanged on simultaneous push and pop.
REQ-019 i_tready SHALL equal reset_n & ((count != DEPTH) | o_tready), so that a push into a full FIFO is permitted in the same cycle as a pop.
REQ-020 o_tvalid SHALL equal (count != 0), and o_tdata SHALL equal mem[rd_ptr].
REQ-021 Latency SHALL be 1 cycle: a beat pushed at edge N is visible on o_tdata/o_tvalid after edge N.
REQ-022 Beats SHALL be delivered in order with no loss or duplication, and o_tdata SHALL be held stable while o_tvalid & ~o_tready.
REQ-023 When empty with a simultaneous push and pop attempt, the FIFO SHALL perform no pop (o_tvalid is low) and the push SHALL occur.
REQ-024 clear SHALL zero rd_ptr, wr_ptr and count at the next edge, and any push or pop in that same cycle SHALL be discarded; memory contents are not cleared.
REQ-025 space and occupied SHALL be registered-derived from count, and their sum SHALL always equal DEPTH.

Reset
REQ-026 Asserting reset_n low SHALL immediately force rd_ptr, wr_ptr and count to 0 and all memory entries to 0, independent of clk.
REQ-027 While reset_n is low, i_tready and o_tvalid SHALL be 0, occupied SHALL be 0 and space SHALL be DEPTH.
REQ-028 Reset asserted mid-transfer SHALL discard all stored beats, and the first edge after deassertion SHALL accept a push normally.

Configuration
REQ-029 With macro AXI_FIFO_FLOPN_BYPASS_EN defined, when count == 0, i_tvalid and o_tready are all high, the beat SHALL pass combinationally (o_tvalid = 1, o_tdata = i_tdata) with no storage and count remaining 0.
REQ-030 With AXI_FIFO_FLOPN_BYPASS_EN defined and count == 0 but o_tready low, the input SHALL be stored normally, so latency is 0 cycles when empty and downstream is ready.
REQ-031 Without AXI_FIFO_FLOPN_BYPASS_EN, behaviour SHALL be exactly REQ-015..REQ-025 with 1-cycle minimum latency.

Verification
REQ-032 With DEPTH=4, o_tready=0, push 0xA0..0xA3 -> i_tready=0 after the 4th push, occupied=4, space=0, o_tdata=0xA0.
REQ-033 From full, hold i_tvalid=1 with 0xA4 and o_tready=1 for one cycle -> 0xA0 popped, 0xA4 stored, occupied stays 4, output order A1,A2,A3,A4.
REQ-034 Continuous streaming with i_tvalid=o_tready=1 for 20 beats of an incrementing pattern -> one beat per cycle with 1-cycle lag, occupied=1 steady, pointers wrap correctly.
REQ-035 With 3 beats stored, pulse clear with push 0x55 in the same cycle -> next cycle occupied=0, o_tvalid=0, 0x55 is never output.
REQ-036 Drop reset_n asynchronously between edges with 2 beats stored -> o_tvalid=0 and space=4 immediately; after release, push 0x77 appears at the output one cycle later.
REQ-037 With AXI_FIFO_FLOPN_BYPASS_EN, empty FIFO, o_tready=1, push 0x99 -> o_tvalid=1 and o_tdata=0x99 in the same cycle, with occupied remaining 0.
